// File: rtl/bf16_pkg.sv
// Shared definitions for the bfloat16 -> int16 converter.
// Holds the exponent bias, the converter FSM state encoding, the bit
// positions inside the 3-bit flag vector and the int16 saturation limits.
package bf16_pkg;

  localparam int BF16_BIAS = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int FLAG_INEXACT  = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INVALID  = 2;

  localparam logic [15:0] INT16_MAX = 16'h7FFF;
  localparam logic [15:0] INT16_MIN = 16'h8000;

endpackage

// File: rtl/bf16_rne_round.sv
// Round-half-even and sign application for an aligned integer magnitude.
// Purely combinational so it can also be dropped into the adder datapath.
// Ports:
//   mag_i     : unsigned aligned magnitude (integer part)
//   g_i       : guard bit (first bit below the integer LSB)
//   s_i       : sticky bit (OR of every bit below the guard)
//   sign_i    : 1 = negate the rounded magnitude
//   result_o  : two's-complement rounded result
//   inexact_o : any nonzero bit was discarded
module bf16_rne_round (
  input  logic [15:0] mag_i,
  input  logic        g_i,
  input  logic        s_i,
  input  logic        sign_i,
  output logic [15:0] result_o,
  output logic        inexact_o
);

  logic        inc;
  logic [15:0] rounded;

  // Ties (g=1, s=0) round up only when that makes the result even.
  assign inc       = g_i & (s_i | mag_i[0]);
  // Magnitude never exceeds 32640, so the increment cannot wrap.
  assign rounded   = mag_i + {15'd0, inc};
  // A zero magnitude negates to zero, so -0 comes out as 16'h0000.
  assign result_o  = sign_i ? (~rounded + 16'd1) : rounded;
  assign inexact_o = g_i | s_i;

endmodule

// File: rtl/bf16_to_int16.sv
// Converts one bfloat16 operand to a saturating two's-complement int16.
// Special operands (NaN, inf, out of range, zero/subnormal, |x| < 0.5)
// are resolved on acceptance; normal operands are aligned one bit per
// cycle, then rounded half-even in a single ROUND cycle.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : operand offered
//   in_ready  : converter idle and able to accept
//   in_data   : bfloat16 {sign, exp[7:0], frac[6:0]}
//   out_valid : result held (DONE)
//   out_ready : consumer accepts the result
//   out_data  : int16 result
//   out_flags : {invalid, overflow, inexact}
module bf16_to_int16
  import bf16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [2:0]  out_flags
);

  state_e             state_q;
  logic [15:0]        mag_q;
  logic               g_q, s_q, sign_q, right_q;
  logic [3:0]         cnt_q;
  logic [15:0]        out_data_q;
  logic [2:0]         out_flags_q;

  logic               sign_in;
  logic [7:0]         exp_field;
  logic [6:0]         frac;
  logic signed [8:0]  unbiased;
  logic signed [8:0]  shift_diff;
  logic [3:0]         k_d;
  logic               special_d;
  logic [15:0]        spec_data_d;
  logic [2:0]         spec_flags_d;

  logic [15:0]        rnd_result;
  logic               rnd_inexact;

  // Field extraction and special-case classification of the offered operand.
  always_comb begin
    sign_in      = in_data[15];
    exp_field    = in_data[14:7];
    frac         = in_data[6:0];
    unbiased     = signed'({1'b0, exp_field} - 9'(BF16_BIAS));
    shift_diff   = unbiased - 9'sd7;
    // Only used on the normal path (-1 <= E <= 14), where |E-7| <= 8.
    k_d          = shift_diff[8] ? 4'(-shift_diff) : 4'(shift_diff);
    special_d    = 1'b1;
    spec_data_d  = 16'h0000;
    spec_flags_d = 3'b000;
    if (exp_field == 8'hFF && frac != 7'd0) begin
      spec_data_d                = INT16_MIN;
      spec_flags_d[FLAG_INVALID] = 1'b1;
    end else if (exp_field == 8'hFF) begin
      spec_data_d                 = sign_in ? INT16_MIN : INT16_MAX;
      spec_flags_d[FLAG_OVERFLOW] = 1'b1;
    end else if (unbiased == 9'sd15 && sign_in && frac == 7'd0) begin
      // -32768 is exactly representable.
      spec_data_d = INT16_MIN;
    end else if (unbiased >= 9'sd15) begin
      spec_data_d                 = sign_in ? INT16_MIN : INT16_MAX;
      spec_flags_d[FLAG_OVERFLOW] = 1'b1;
    end else if (exp_field == 8'h00) begin
      // Subnormals are flushed; only the inexact flag remembers them.
      spec_flags_d[FLAG_INEXACT] = (frac != 7'd0);
    end else if (unbiased < -9'sd1) begin
      spec_flags_d[FLAG_INEXACT] = 1'b1;
    end else begin
      special_d = 1'b0;
    end
  end

  bf16_rne_round u_round (
    .mag_i     (mag_q),
    .g_i       (g_q),
    .s_i       (s_q),
    .sign_i    (sign_q),
    .result_o  (rnd_result),
    .inexact_o (rnd_inexact)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mag_q       <= 16'h0000;
      g_q         <= 1'b0;
      s_q         <= 1'b0;
      sign_q      <= 1'b0;
      right_q     <= 1'b0;
      cnt_q       <= 4'd0;
      out_data_q  <= 16'h0000;
      out_flags_q <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q <= sign_in;
            if (special_d) begin
              out_data_q  <= spec_data_d;
              out_flags_q <= spec_flags_d;
              state_q     <= DONE;
            end else begin
              mag_q   <= {8'h00, 1'b1, frac};
              g_q     <= 1'b0;
              s_q     <= 1'b0;
              cnt_q   <= k_d;
              right_q <= (unbiased < 9'sd7);
              state_q <= (k_d == 4'd0) ? ROUND : ALIGN;
            end
          end
        end
        ALIGN: begin
          if (right_q) begin
            // The previous guard drops into sticky as a new bit leaves.
            mag_q <= {1'b0, mag_q[15:1]};
            g_q   <= mag_q[0];
            s_q   <= s_q | g_q;
          end else begin
            mag_q <= {mag_q[14:0], 1'b0};
          end
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= ROUND;
        end
        ROUND: begin
          out_data_q  <= rnd_result;
          out_flags_q <= {2'b00, rnd_inexact};
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode the state register only, so in_ready never
  // sees out_ready combinationally.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_bf16_to_int16.sv
module tb_bf16_to_int16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_flags;

  int checks = 0;
  int errors = 0;

  bf16_to_int16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one operand, measure cycles until out_valid, check the result,
  // then transfer it. Latency counts the acceptance edge as 1.
  task automatic run_op(input string tag, input logic [15:0] din,
                        input logic [15:0] exp_data, input logic [2:0] exp_flags,
                        input int exp_lat);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
    in_valid = 1'b1;
    in_data  = din;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 16'(lat), 16'(exp_lat));
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_flags"}, {13'd0, out_flags}, {13'd0, exp_flags});
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_released"}, {14'd0, out_valid, in_ready}, 16'b01);
  endtask

  initial begin
    logic [15:0] held;
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", {15'd0, in_ready}, 16'd1);
    check("reset_out_valid", {15'd0, out_valid}, 16'd0);
    check("reset_out_data", out_data, 16'h0000);
    check("reset_out_flags", {13'd0, out_flags}, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // Normal path: latency k+2
    run_op("p1_5",    16'h3FC0, 16'h0002, 3'b001, 9);
    run_op("p2_5",    16'h4020, 16'h0002, 3'b001, 8);
    run_op("p3_0",    16'h4040, 16'h0003, 3'b000, 8);
    run_op("p123_5",  16'h42F7, 16'h007C, 3'b001, 3);
    run_op("n123_5",  16'hC2F7, 16'hFF84, 3'b001, 3);
    run_op("p128",    16'h4300, 16'h0080, 3'b000, 2);
    run_op("p32640",  16'h46FF, 16'h7F80, 3'b000, 9);
    run_op("p0_5",    16'h3F00, 16'h0000, 3'b001, 10);
    run_op("n0_5",    16'hBF00, 16'h0000, 3'b001, 10);
    // Special path: latency 1
    run_op("m32768",  16'hC700, 16'h8000, 3'b000, 1);
    run_op("p32768",  16'h4700, 16'h7FFF, 3'b010, 1);
    run_op("nan",     16'h7FC0, 16'h8000, 3'b100, 1);
    run_op("ninf",    16'hFF80, 16'h8000, 3'b010, 1);
    run_op("pinf",    16'h7F80, 16'h7FFF, 3'b010, 1);
    run_op("n65536",  16'hC780, 16'h8000, 3'b010, 1);
    run_op("zero",    16'h0000, 16'h0000, 3'b000, 1);
    run_op("subnorm", 16'h0001, 16'h0000, 3'b001, 1);
    run_op("p0_25",   16'h3E80, 16'h0000, 3'b001, 1);

    // Backpressure: result held for 5 cycles while a new operand waits.
    in_valid = 1'b1;
    in_data  = 16'h4040;
    @(posedge clk);
    #1 in_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("hold_valid", {15'd0, out_valid}, 16'd1);
    held     = out_data;
    in_valid = 1'b1;
    in_data  = 16'h3F00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_data", out_data, 16'h0003);
      check("hold_stable", out_data, held);
      check("hold_in_ready", {15'd0, in_ready}, 16'd0);
      check("hold_out_valid", {15'd0, out_valid}, 16'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("b2b_idle", {14'd0, out_valid, in_ready}, 16'b01);
    in_valid = 1'b0;
    run_op("b2b_p0_5", 16'h3F00, 16'h0000, 3'b001, 10);

    // Reset in the middle of ALIGN abandons the operand.
    in_valid = 1'b1;
    in_data  = 16'h3FC0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {15'd0, in_ready}, 16'd0);
    rst = 1'b1;
    #1;
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_out_data", out_data, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_out_valid", {15'd0, out_valid}, 16'd0);
    run_op("post_rst_3_0", 16'h4040, 16'h0003, 3'b000, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf16_to_int16.md
BF16_TO_INT16 -- requirements
Module: bf16_to_int16

Interface
REQ-001 The module SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Ports SHALL be exactly: clk input 1 rising-edge clock; rst input 1 async active-high reset; in_valid input 1 operand offered; in_ready output 1 operand accepted when high with in_valid; in_data input 16 bfloat16 operand {sign, exp[7:0], frac[6:0]}; out_valid output 1 result held; out_ready input 1 consumer accepts; out_data output 16 two's-complement signed int16 result; out_flags output 3 {invalid, overflow, inexact}.

Function
REQ-003 Input acceptance SHALL occur on a rising edge with in_valid & in_ready; output transfer SHALL occur on a rising edge with out_valid & out_ready.
REQ-004 States SHALL be IDLE, ALIGN, ROUND, DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-005 Fields SHALL be e = in_data[14:7], E = e - 127 (signed), sig = {1, in_data[6:0]} (8 bits).
REQ-006 If e = 255 and frac != 0 (NaN), the result SHALL be 16'h8000 with invalid = 1, going IDLE->DONE.
REQ-007 If e = 255 and frac = 0 (inf), or if E >= 15 except the -32768 case, the result SHALL saturate to 16'h7FFF (sign 0) or 16'h8000 (sign 1) with overflow = 1, going IDLE->DONE.
REQ-008 If sign = 1, E = 15, and frac = 0, the result SHALL be 16'h8000 with no flags, going IDLE->DONE.
REQ-009 If e = 0 (zero or subnormal, flushed), the result SHALL be 16'h0000, with inexact = (frac != 0), going IDLE->DONE.
REQ-010 If -127 < E < -1, the result SHALL be 16'h0000 with inexact = 1, going IDLE->DONE.
REQ-011 For -1 <= E <= 14, the shift count SHALL be k = |E - 7|, with magnitude = sig shifted right (E < 7) or left (E > 7).
REQ-012 In the REQ-011 case, ALIGN SHALL shift exactly one bit per cycle for k cycles, and SHALL be skipped when k = 0.
REQ-013 On right shifts, guard g SHALL be the last bit shifted out and sticky s SHALL be the OR of all earlier bits shifted out.
REQ-014 ROUND SHALL last one cycle, applying round-half-even (increment iff g & (s | lsb)), setting inexact = g | s, and negating if sign = 1; -0 SHALL give 16'h0000.
REQ-015 Latency SHALL be: acceptance at edge T; normal path out_valid high after edge T+k+2; special path (REQ-006..010) out_valid high after edge T+1.
REQ-016 In DONE, out_data and out_flags SHALL be held stable until the transfer edge, after which the FSM SHALL return to IDLE.
REQ-017 in_ready SHALL NOT depend combinationally on out_ready, so at least one IDLE cycle SHALL separate consecutive results.
REQ-018 The magnitude datapath SHALL be at least 16 bits (max 255<<7 = 32640) so the post-round magnitude never wraps.
REQ-019 Internal shift counter width SHALL be 4 bits; k SHALL never exceed 8.

Reset
REQ-020 While rst is high, state SHALL be IDLE, in_ready = 1, out_valid = 0, out_data = 16'h0000, and out_flags = 3'b000.
REQ-021 Reset asserted in ALIGN, ROUND, or DONE SHALL abandon the operand with no output transfer; the first edge after deassertion SHALL be able to accept.

Structure
REQ-022 Package bf16_pkg SHALL hold BF16_BIAS = 127, the FSM state enum, flag bit indices (FLAG_INEXACT = 0, FLAG_OVERFLOW = 1, FLAG_INVALID = 2), and INT16_MAX / INT16_MIN constants.
REQ-023 Rounding and negation SHALL be one combinational sub-module, bf16_rne_round (inputs magnitude, g, s, sign; outputs result, inexact), reusable by the adder datapath.

Verification
REQ-024 The bench SHALL drive 0x3FC0 (1.5) -> 0x0002, flags 001, out_valid after edge T+9 (k = 7).
REQ-025 The bench SHALL drive 0x4020 (2.5) -> 0x0002 with inexact, and 0x4040 (3.0) -> 0x0003 with flags 000.
REQ-026 The bench SHALL drive 0x42F7 (123.5) -> 0x007C inexact, and 0xC2F7 -> 0xFF84 inexact.
REQ-027 The bench SHALL drive 0xC700 -> 0x8000 flags 000; 0x4700 -> 0x7FFF overflow; 0x7FC0 -> 0x8000 invalid; 0xFF80 -> 0x8000 overflow.
REQ-028 The bench SHALL hold out_ready = 0 for 5 cycles in DONE and require out_data stable and in_ready = 0 throughout; then a back-to-back in_valid SHALL be accepted only after the return to IDLE.
REQ-029 The bench SHALL pulse rst during ALIGN of 0x3FC0 and require out_valid = 0, in_ready = 1, and no stale result on the next operand 0x4040 -> 0x0003.
